// File: rtl/neuro_cmd_sequencer.sv
// UART command sequencer for the neural core: parses opcodes, loads operand
// arrays, triggers a multiply and streams result bytes back out of the UART.
module neuro_cmd_sequencer #(
    parameter int          N       = 2,
    parameter int          ADDR_W  = 2,
    parameter logic [23:0] TIMEOUT = 24'd10_000_000
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_error,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mult_start,
    input  logic              mult_done,
    output logic [ADDR_W-1:0] res_addr,
    input  logic [7:0]        res_data,
    output logic              load_arr,
    output logic              busy,
    output logic              cmd_error
);

    localparam logic [7:0] OP_LOAD_W = 8'hA1;
    localparam logic [7:0] OP_LOAD_X = 8'hA2;
    localparam logic [7:0] OP_RUN    = 8'hA3;
    localparam logic [7:0] BYTE_ACK  = 8'hAC;
    localparam logic [7:0] BYTE_ERR  = 8'hEE;

    localparam logic [ADDR_W-1:0] W_LAST = ADDR_W'(N * N - 1);
    localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(N - 1);

    typedef enum logic [3:0] {
        IDLE,
        LOAD_W,
        LOAD_X,
        RUN_START,
        RUN_WAIT,
        TX_LOAD,
        TX_LATCH,
        TX_SEND,
        TX_WAIT
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] k;
    logic [23:0]       tmo;
    logic              first;
    logic              res_mode;

    logic              send_byte;
    logic [7:0]        byte_val;
    logic              set_err;
    logic              clr_err;
    logic              idx_clr;
    logic              idx_inc;
    logic              k_clr;
    logic              k_inc;
    logic              latch_res;
    logic [ADDR_W-1:0] idx_last;

    assign idx_last  = (state == LOAD_W) ? W_LAST : X_LAST;
    assign mem_sel   = (state == LOAD_X);
    assign mem_addr  = load_arr ? idx : '0;
    assign mem_wdata = mem_we ? rx_data : 8'h00;
    assign res_addr  = k;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        send_byte  = 1'b0;
        byte_val   = 8'h00;
        set_err    = 1'b0;
        clr_err    = 1'b0;
        idx_clr    = 1'b0;
        idx_inc    = 1'b0;
        k_clr      = 1'b0;
        k_inc      = 1'b0;
        latch_res  = 1'b0;
        tx_start   = 1'b0;
        mult_start = 1'b0;
        mem_we     = 1'b0;
        load_arr   = (state == LOAD_W) || (state == LOAD_X);
        busy       = (state != IDLE);

        unique case (state)
            IDLE: begin
                // A framing error wins over a byte arriving in the same cycle.
                if (rx_error) begin
                    set_err = 1'b1;
                end else if (rx_valid) begin
                    unique case (rx_data)
                        OP_LOAD_W: begin
                            clr_err  = 1'b1;
                            idx_clr  = 1'b1;
                            state_nx = LOAD_W;
                        end
                        OP_LOAD_X: begin
                            clr_err  = 1'b1;
                            idx_clr  = 1'b1;
                            state_nx = LOAD_X;
                        end
                        OP_RUN: begin
                            clr_err  = 1'b1;
                            state_nx = RUN_START;
                        end
                        default: begin
                            set_err   = 1'b1;
                            send_byte = 1'b1;
                            byte_val  = BYTE_ERR;
                            state_nx  = TX_SEND;
                        end
                    endcase
                end
            end
            LOAD_W, LOAD_X: begin
                if (rx_error) begin
                    set_err   = 1'b1;
                    send_byte = 1'b1;
                    byte_val  = BYTE_ERR;
                    state_nx  = TX_SEND;
                end else if (rx_valid) begin
                    mem_we  = 1'b1;
                    idx_inc = 1'b1;
                    if (idx == idx_last) begin
                        send_byte = 1'b1;
                        byte_val  = BYTE_ACK;
                        state_nx  = TX_SEND;
                    end
                end else if (tmo == (TIMEOUT - 24'd1)) begin
                    set_err  = 1'b1;
                    state_nx = IDLE;
                end
            end
            RUN_START: begin
                mult_start = 1'b1;
                state_nx   = RUN_WAIT;
            end
            RUN_WAIT: begin
                if (mult_done) begin
                    k_clr    = 1'b1;
                    state_nx = TX_LOAD;
                end
            end
            TX_LOAD: begin
                state_nx = TX_LATCH;
            end
            TX_LATCH: begin
                latch_res = 1'b1;
                state_nx  = TX_SEND;
            end
            TX_SEND: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_nx = TX_WAIT;
                end
            end
            TX_WAIT: begin
                // The transmitter only raises busy the cycle after tx_start.
                if (!first && !tx_busy) begin
                    if (res_mode && (k != K_LAST)) begin
                        k_inc    = 1'b1;
                        state_nx = TX_LOAD;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            idx       <= '0;
            k         <= '0;
            tmo       <= '0;
            tx_data   <= 8'h00;
            cmd_error <= 1'b0;
            first     <= 1'b0;
            res_mode  <= 1'b0;
        end else begin
            first <= tx_start;

            if (idx_clr) begin
                idx <= '0;
            end else if (idx_inc) begin
                idx <= idx + ADDR_W'(1);
            end

            if (idx_clr || (load_arr && rx_valid)) begin
                tmo <= '0;
            end else if (load_arr) begin
                tmo <= tmo + 24'd1;
            end

            if (send_byte) begin
                tx_data  <= byte_val;
                res_mode <= 1'b0;
            end else if (latch_res) begin
                tx_data <= res_data;
            end

            if (k_clr) begin
                k        <= '0;
                res_mode <= 1'b1;
            end else if (k_inc) begin
                k <= k + ADDR_W'(1);
            end

            if (clr_err) begin
                cmd_error <= 1'b0;
            end else if (set_err) begin
                cmd_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_neuro_cmd_sequencer.sv
// Directed bench for neuro_cmd_sequencer with small UART-TX and multiplier
// responders; expected values are hand-derived from the command protocol.
module tb_neuro_cmd_sequencer;

    logic       CLK;
    logic       RESET;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_error;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       mem_we;
    logic       mem_sel;
    logic [1:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mult_start;
    logic       mult_done;
    logic [1:0] res_addr;
    logic [7:0] res_data;
    logic       load_arr;
    logic       busy;
    logic       cmd_error;

    int checks = 0;
    int errors = 0;

    logic [7:0] tx_log[$];
    logic       we_sel[$];
    logic [1:0] we_addr[$];
    logic [7:0] we_data[$];
    int         mult_starts = 0;
    int         mult_cnt = 0;
    int         busy_cnt = 0;
    logic       tx_pend = 1'b0;
    logic [1:0] ra_q = 2'd0;
    int         tx_before;

    neuro_cmd_sequencer #(.N(2), .ADDR_W(2), .TIMEOUT(24'd100)) dut (
        .CLK(CLK), .RESET(RESET),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_error(rx_error),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mult_start(mult_start), .mult_done(mult_done),
        .res_addr(res_addr), .res_data(res_data),
        .load_arr(load_arr), .busy(busy), .cmd_error(cmd_error)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Observe DUT outputs mid-cycle.
    always @(negedge CLK) begin
        if (tx_start) begin
            tx_log.push_back(tx_data);
            tx_pend = 1'b1;
        end
        if (mem_we) begin
            we_sel.push_back(mem_sel);
            we_addr.push_back(mem_addr);
            we_data.push_back(mem_wdata);
        end
        if (mult_start) begin
            mult_starts++;
            mult_cnt = 10;
        end
        ra_q = res_addr;
    end

    // Transmitter busy for 3 cycles starting the cycle after tx_start;
    // multiplier answers 10 cycles after mult_start; result RAM has 1-cycle latency.
    always @(posedge CLK) begin
        #1;
        if (tx_pend) begin
            tx_busy  = 1'b1;
            busy_cnt = 3;
            tx_pend  = 1'b0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_busy = 1'b0;
        end
        if (mult_cnt > 0) begin
            mult_cnt--;
            mult_done = (mult_cnt == 0);
        end else begin
            mult_done = 1'b0;
        end
        res_data = (ra_q == 2'd0) ? 8'h11 : (ra_q == 2'd1) ? 8'h22 : 8'h00;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic err);
        rx_valid = 1'b1;
        rx_data  = b;
        rx_error = err;
        @(posedge CLK); #1;
        rx_valid = 1'b0;
        rx_error = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 300 && tx_log.size() < n; i++) begin
            @(posedge CLK); #1;
        end
        check("wait_tx", tx_log.size(), n);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && busy; i++) begin
            @(posedge CLK); #1;
        end
        check("wait_idle", busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_txdata"}, tx_data, 0);
        check({tag, "_txstart"}, tx_start, 0);
        check({tag, "_mult"}, mult_start, 0);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_load"}, load_arr, 0);
        check({tag, "_resaddr"}, res_addr, 0);
        check({tag, "_err"}, cmd_error, 0);
    endtask

    initial begin
        RESET = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_error = 1'b0;
        tx_busy = 1'b0; mult_done = 1'b0; res_data = 8'h00;
        cycles(3);
        check_all_zero("reset");
        RESET = 1'b0;
        cycles(2);

        // Weight load
        send(8'hA1, 1'b0);
        check("t1_load_arr", load_arr, 1);
        check("t1_sel", mem_sel, 0);
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
        wait_tx(1);
        check("t1_ack", tx_log[0], 8'hAC);
        wait_idle();
        check("t1_nwr", we_data.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("t1_wsel", we_sel[i], 0);
            check("t1_waddr", we_addr[i], i);
            check("t1_wdata", we_data[i], i + 1);
        end
        check("t1_load_low", load_arr, 0);

        // Input load then run
        send(8'hA2, 1'b0);
        check("t2_sel", mem_sel, 1);
        send(8'h05, 1'b0); send(8'h06, 1'b0);
        wait_tx(2);
        check("t2_ack", tx_log[1], 8'hAC);
        wait_idle();
        check("t2_nwr", we_data.size(), 6);
        check("t2_w0", {we_sel[4], we_addr[4], we_data[4]}, {1'b1, 2'd0, 8'h05});
        check("t2_w1", {we_sel[5], we_addr[5], we_data[5]}, {1'b1, 2'd1, 8'h06});
        send(8'hA3, 1'b0);
        wait_tx(4);
        wait_idle();
        check("t2_mult_starts", mult_starts, 1);
        check("t2_res0", tx_log[2], 8'h11);
        check("t2_res1", tx_log[3], 8'h22);

        // Bad opcode
        send(8'h5A, 1'b0);
        check("t3_err_set", cmd_error, 1);
        wait_tx(5);
        check("t3_ee", tx_log[4], 8'hEE);
        wait_idle();
        check("t3_err_held", cmd_error, 1);
        send(8'hA2, 1'b0);
        check("t3_err_clr", cmd_error, 0);
        send(8'h07, 1'b0); send(8'h08, 1'b0);
        wait_tx(6);
        check("t3_ack", tx_log[5], 8'hAC);
        wait_idle();

        // Payload timeout
        send(8'hA1, 1'b0);
        send(8'h01, 1'b0);
        cycles(50);
        check("t4_still_loading", busy, 1);
        check("t4_err_early", cmd_error, 0);
        cycles(60);
        check("t4_idle", busy, 0);
        check("t4_err", cmd_error, 1);
        check("t4_no_tx", tx_log.size(), 6);
        check("t4_nwr", we_data.size(), 9);
        check("t4_wr", {we_sel[8], we_addr[8], we_data[8]}, {1'b0, 2'd0, 8'h01});

        // Framing error colliding with a payload byte
        send(8'hA2, 1'b0);
        check("t5_err_clr", cmd_error, 0);
        send(8'h09, 1'b1);
        check("t5_no_we", we_data.size(), 9);
        wait_tx(7);
        check("t5_ee", tx_log[6], 8'hEE);
        wait_idle();
        check("t5_err", cmd_error, 1);

        // Reset during RUN_WAIT
        send(8'hA3, 1'b0);
        for (int i = 0; i < 20 && mult_starts < 2; i++) begin
            @(posedge CLK); #1;
        end
        check("t6_mult_starts", mult_starts, 2);
        cycles(3);
        check("t6_in_wait", busy, 1);
        RESET = 1'b1;
        #1;
        check_all_zero("t6a");
        cycles(1);
        RESET = 1'b0;
        cycles(15);
        check("t6_done_ignored", busy, 0);
        check("t6_no_tx", tx_log.size(), 7);

        // Reset during TX_WAIT
        send(8'hA3, 1'b0);
        wait_tx(8);
        check("t6_res0", tx_log[7], 8'h11);
        RESET = 1'b1;
        #1;
        check_all_zero("t6b");
        cycles(1);
        RESET = 1'b0;
        cycles(2);

        // Fresh frame after reset
        send(8'hA2, 1'b0);
        send(8'h0A, 1'b0); send(8'h0B, 1'b0);
        wait_tx(9);
        check("t6_ack", tx_log[8], 8'hAC);
        wait_idle();
        check("t6_nwr", we_data.size(), 11);
        check("t6_w0", {we_sel[9], we_addr[9], we_data[9]}, {1'b1, 2'd0, 8'h0A});
        check("t6_w1", {we_sel[10], we_addr[10], we_data[10]}, {1'b1, 2'd1, 8'h0B});
        check("t6_tx_total", tx_log.size(), 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
